// File: rtl/vh_stim_capture.sv
// vh_stim_capture
//   Stimulus/response harness for combinational expression blocks.
//   A 60-bit LFSR supplies operand vectors on op_out. After LAT+1 settle
//   cycles the 90-bit result y_in is folded into a MISR signature. This repeats
//   for NUM_VEC vectors, and then the block parks in DONE.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   start      : single-cycle pulse, begins a run from IDLE or DONE
//   abort      : returns to IDLE from any state; signature and count hold
//   op_out     : operand bundle (the LFSR register itself)
//   y_in       : DUT result, sampled only in CAPTURE
//   busy       : high in SETTLE and CAPTURE
//   done       : high in DONE
//   vec_count  : vectors captured in the current run
//   signature  : MISR contents
//   state_dbg  : current FSM state (IDLE=0, SETTLE=1, CAPTURE=2, DONE=3)
//
// Control semantics: start and abort are level-sampled on every rising edge
// with no handshake back. start is acted on only in IDLE or DONE and is
// ignored while busy. abort wins over start and over a CAPTURE update. reset
// wins over everything.
module vh_stim_capture #(
  parameter logic [59:0] SEED    = 60'h1,
  parameter int unsigned NUM_VEC = 256,
  parameter int unsigned LAT     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [59:0] op_out,
  input  logic [89:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] vec_count,
  output logic [89:0] signature,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [59:0] SEED_EFF = (SEED == 60'h0) ? 60'h1 : SEED;
  localparam logic [15:0] NV16     = 16'(NUM_VEC);
  localparam logic [7:0]  LAT8     = 8'(LAT);

  state_t        state;
  state_t        state_nxt;
  logic [59:0]   lfsr;
  logic [89:0]   sig;
  logic [7:0]    settle_cnt;
  logic          last_vec;
  logic          fb;

  assign last_vec = (vec_count + 16'd1) == NV16;
  assign fb       = sig[89] ^ sig[88] ^ sig[87] ^ sig[86];

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = SETTLE;
        SETTLE:  if (settle_cnt == 8'd0) state_nxt = CAPTURE;
        CAPTURE: state_nxt = last_vec ? DONE : SETTLE;
        DONE:    if (start) state_nxt = SETTLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= '0;
      sig        <= '0;
      vec_count  <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!abort) begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              lfsr       <= SEED_EFF;
              sig        <= '0;
              vec_count  <= '0;
              settle_cnt <= LAT8;
            end
          end
          SETTLE: begin
            if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
          end
          CAPTURE: begin
            sig        <= {sig[88:0], fb} ^ y_in;
            vec_count  <= vec_count + 16'd1;
            // Taps 60/59 give a maximal-length sequence that never hits zero.
            lfsr       <= {lfsr[58:0], lfsr[59] ^ lfsr[58]};
            settle_cnt <= LAT8;
          end
          default: ;
        endcase
      end
    end
  end

  assign op_out    = lfsr;
  assign signature = sig;
  assign busy      = (state == SETTLE) || (state == CAPTURE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_vh_stim_capture.sv
module tb_vh_stim_capture;

  localparam int unsigned NV2   = 6;
  localparam int unsigned LAT2  = 3;
  localparam int          P2    = LAT2 + 2;
  localparam logic [59:0] SEED2 = 60'h0123456789abcde;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start01 = 1'b0;
  logic start2 = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic [59:0] op0, op1, op2;
  logic [89:0] y0, y1, y2;
  logic [89:0] sig0, sig1, sig2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [1:0]  st0, st1, st2;

  assign y0 = {30'b0, op0};
  assign y1 = {30'b0, op1};

  vh_stim_capture #(.SEED(60'h1), .NUM_VEC(1), .LAT(0)) u0 (
    .clk(clk), .reset(reset), .start(start01), .abort(1'b0),
    .op_out(op0), .y_in(y0), .busy(busy0), .done(done0),
    .vec_count(cnt0), .signature(sig0), .state_dbg(st0)
  );

  vh_stim_capture #(.SEED(60'h0), .NUM_VEC(2), .LAT(0)) u1 (
    .clk(clk), .reset(reset), .start(start01), .abort(1'b0),
    .op_out(op1), .y_in(y1), .busy(busy1), .done(done1),
    .vec_count(cnt1), .signature(sig1), .state_dbg(st1)
  );

  vh_stim_capture #(.SEED(SEED2), .NUM_VEC(NV2), .LAT(LAT2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort),
    .op_out(op2), .y_in(y2), .busy(busy2), .done(done2),
    .vec_count(cnt2), .signature(sig2), .state_dbg(st2)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [89:0] y_sched [NV2];
  logic [89:0] m_sig;
  logic [89:0] run1_sig;
  logic [59:0] m_lfsr;
  int          m_cnt;

  task automatic check(input string tag, input logic [89:0] got, input logic [89:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [89:0] rand90();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[89:0];
  endfunction

  // MISR: shift left by one, feed back the parity of the top four bits, xor result.
  function automatic logic [89:0] misr_model(input logic [89:0] s, input logic [89:0] y);
    logic [89:0] shifted;
    shifted = s << 1;
    shifted[0] = ^s[89:86];
    return shifted ^ y;
  endfunction

  function automatic logic [59:0] lfsr_model(input logic [59:0] l);
    logic [59:0] n;
    n = l << 1;
    n[0] = l[59] ^ l[58];
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_u2(input string tag);
    check({tag, "_op"}, 90'(op2), 90'h0);
    check({tag, "_sig"}, sig2, 90'h0);
    check({tag, "_cnt"}, 90'(cnt2), 90'h0);
    check({tag, "_busy"}, 90'(busy2), 90'h0);
    check({tag, "_done"}, 90'(done2), 90'h0);
    check({tag, "_state"}, 90'(st2), 90'h0);
  endtask

  // One run on u2. Cycle c counts from 1 (first cycle after the start edge).
  // A zero argument disables the corresponding disturbance.
  task automatic run_u2(input int mid_start_cyc, input int abort_cyc,
                        input int reset_cyc, input bit probe);
    m_lfsr = SEED2;
    m_sig  = '0;
    m_cnt  = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= int'(NV2) * P2; c++) begin
      bit cap;
      int vi;
      cap = ((c - 1) % P2) == (P2 - 1);
      vi  = (c - 1) / P2;
      check("run_busy", 90'(busy2), 90'h1);
      check("run_done", 90'(done2), 90'h0);
      check("run_op", 90'(op2), 90'(m_lfsr));
      check("run_cnt", 90'(cnt2), 90'(m_cnt));
      check("run_sig", sig2, m_sig);
      y2 = cap ? y_sched[vi] : rand90();
      if (c == mid_start_cyc) start2 = 1'b1;
      if (c == abort_cyc) abort = 1'b1;
      if (c == reset_cyc) reset = 1'b1;
      step();
      start2 = 1'b0;
      if (c == abort_cyc) begin
        abort = 1'b0;
        check("abort_busy", 90'(busy2), 90'h0);
        check("abort_done", 90'(done2), 90'h0);
        check("abort_state", 90'(st2), 90'h0);
        check("abort_cnt", 90'(cnt2), 90'(m_cnt));
        check("abort_sig", sig2, m_sig);
        return;
      end
      if (c == reset_cyc) begin
        reset = 1'b0;
        check_reset_u2("midreset");
        return;
      end
      if (cap) begin
        m_sig  = misr_model(m_sig, y2);
        m_cnt++;
        m_lfsr = lfsr_model(m_lfsr);
      end
      if (probe && c == P2)     check("misr_preload", sig2, 90'h1 << 89);
      if (probe && c == 2 * P2) check("misr_fb", sig2, 90'h1);
    end
    check("end_done", 90'(done2), 90'h1);
    check("end_busy", 90'(busy2), 90'h0);
    check("end_cnt", 90'(cnt2), 90'(NV2));
    check("end_sig", sig2, m_sig);
    check("end_op", 90'(op2), 90'(m_lfsr));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    y2 = '0;
    step();
    step();
    reset = 1'b0;
    check_reset_u2("reset");
    check("reset_op0", 90'(op0), 90'h0);
    check("reset_done0", 90'(done0), 90'h0);

    // Basic single vector (u0) and two-vector cancellation with zero seed (u1)
    start01 = 1'b1;
    step();
    start01 = 1'b0;
    // cycle 1
    check("c1_busy0", 90'(busy0), 90'h1);
    check("c1_op0", 90'(op0), 90'h1);
    check("c1_op1_zero_seed", 90'(op1), 90'h1);
    step();
    // cycle 2
    check("c2_busy0", 90'(busy0), 90'h1);
    check("c2_done0", 90'(done0), 90'h0);
    step();
    // cycle 3
    check("c3_done0", 90'(done0), 90'h1);
    check("c3_busy0", 90'(busy0), 90'h0);
    check("c3_sig0", sig0, 90'h1);
    check("c3_cnt0", 90'(cnt0), 90'h1);
    check("c3_op1", 90'(op1), 90'h2);
    check("c3_sig1", sig1, 90'h1);
    step();
    // cycle 4
    check("c4_done1", 90'(done1), 90'h0);
    step();
    // cycle 5
    check("c5_done1", 90'(done1), 90'h1);
    check("c5_sig1", sig1, 90'h0);
    check("c5_cnt1", 90'(cnt1), 90'h2);

    // Randomized run with LAT=3
    for (int i = 0; i < int'(NV2); i++) y_sched[i] = rand90();
    run_u2(0, 0, 0, 1'b0);
    run1_sig = m_sig;

    // Restart from DONE with an ignored start mid-run: identical signature
    run_u2(7, 0, 0, 1'b0);
    check("restart_same_sig", sig2, run1_sig);

    // Abort during SETTLE of the third vector
    run_u2(2 * P2 + 2, 0, 0, 1'b0);
    run_u2(0, 2 * P2 + 2, 0, 1'b0);
    step();
    check("abort_idle_hold_cnt", 90'(cnt2), 90'h2);

    // MISR feedback: preload top bit, then zero result shifts in fb=1
    y_sched[0] = 90'h1 << 89;
    y_sched[1] = '0;
    for (int i = 2; i < int'(NV2); i++) y_sched[i] = rand90();
    run_u2(0, 0, 0, 1'b1);

    // Reset on the first CAPTURE cycle: capture discarded
    run_u2(0, 0, P2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
